// File: rtl/pattern_detector_pkg.sv
// Shared types and default configuration for the sequential pattern detector.
// The default pattern is letter0 = (11,10), letter1 = (11,00), with letter0 sym0 in the LSBs.
package pattern_detector_pkg;

    typedef enum logic [1:0] {
        StHunt = 2'd0,
        StDone = 2'd1,
        StHold = 2'd2
    } state_e;

    localparam int unsigned DEF_SYM_W           = 2;
    localparam int unsigned DEF_SYMS_PER_LETTER = 2;
    localparam int unsigned DEF_NUM_LETTERS     = 2;
    localparam int unsigned DEF_COUNT_W         = 8;
    localparam int unsigned DEF_CONTINUOUS      = 1;
    localparam logic [7:0]  DEF_RST_PATTERN     = 8'b00_11_10_11;

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int unsigned idx_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Clear takes priority over increment; the count holds at all-ones.
module sat_counter #(
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               clr,
    output logic [COUNT_W-1:0] count
);

    logic [COUNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pattern_detector_seq.sv
// Detects a programmable sequence of multi-symbol letters on a symbol stream,
// reporting per-letter progress, a one-cycle done pulse and a saturating match count.
module pattern_detector_seq
    import pattern_detector_pkg::*;
#(
    parameter int unsigned SYM_W           = DEF_SYM_W,
    parameter int unsigned SYMS_PER_LETTER = DEF_SYMS_PER_LETTER,
    parameter int unsigned NUM_LETTERS     = DEF_NUM_LETTERS,
    parameter int unsigned COUNT_W         = DEF_COUNT_W,
    parameter int unsigned CONTINUOUS      = DEF_CONTINUOUS,
    parameter logic [NUM_LETTERS*SYMS_PER_LETTER*SYM_W-1:0] RST_PATTERN = DEF_RST_PATTERN
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [SYM_W-1:0]                         sym,
    input  logic                                     sym_valid,
    input  logic                                     clear,
    input  logic                                     cfg_load,
    input  logic [NUM_LETTERS*SYMS_PER_LETTER*SYM_W-1:0] cfg_pattern,
    output logic [NUM_LETTERS-1:0]                   letter_detected,
    output logic                                     seq_done,
    output logic [COUNT_W-1:0]                       match_count
);

    localparam int unsigned PAT_W = NUM_LETTERS * SYMS_PER_LETTER * SYM_W;
    localparam int unsigned LIW   = idx_w(NUM_LETTERS);
    localparam int unsigned SIW   = idx_w(SYMS_PER_LETTER);
    localparam logic [LIW-1:0] LAST_LETTER = LIW'(NUM_LETTERS - 1);
    localparam logic [SIW-1:0] LAST_SYM    = SIW'(SYMS_PER_LETTER - 1);

    state_e                 state_q, state_d;
    logic [LIW-1:0]         letter_idx_q, letter_idx_d;
    logic [SIW-1:0]         sym_idx_q, sym_idx_d;
    logic [NUM_LETTERS-1:0] letter_det_q, letter_det_d;
    logic [PAT_W-1:0]       pattern_q, pattern_d;
    logic                   cnt_inc, cnt_clr;
    logic                   idx_ok;
    logic [SYM_W-1:0]       exp_sym, first_sym;

    assign idx_ok    = (32'(letter_idx_q) < NUM_LETTERS) && (32'(sym_idx_q) < SYMS_PER_LETTER);
    assign exp_sym   = pattern_q[(32'(letter_idx_q) * SYMS_PER_LETTER + 32'(sym_idx_q)) * SYM_W
                                 +: SYM_W];
    assign first_sym = pattern_q[32'(letter_idx_q) * SYMS_PER_LETTER * SYM_W +: SYM_W];

    always_comb begin
        state_d      = state_q;
        letter_idx_d = letter_idx_q;
        sym_idx_d    = sym_idx_q;
        letter_det_d = letter_det_q;
        pattern_d    = pattern_q;
        cnt_inc      = 1'b0;
        cnt_clr      = 1'b0;

        if (clear) begin
            state_d      = StHunt;
            letter_idx_d = '0;
            sym_idx_d    = '0;
            letter_det_d = '0;
            cnt_clr      = 1'b1;
        end else if (cfg_load) begin
            pattern_d    = cfg_pattern;
            state_d      = StHunt;
            letter_idx_d = '0;
            sym_idx_d    = '0;
            letter_det_d = '0;
        end else begin
            unique case (state_q)
                StHunt: begin
                    if (!idx_ok) begin
                        letter_idx_d = '0;
                        sym_idx_d    = '0;
                        letter_det_d = '0;
                    end else if (sym_valid) begin
                        if (sym == exp_sym) begin
                            if (sym_idx_q == LAST_SYM) begin
                                letter_det_d[letter_idx_q] = 1'b1;
                                sym_idx_d = '0;
                                if (letter_idx_q == LAST_LETTER) begin
                                    state_d      = StDone;
                                    letter_idx_d = '0;
                                    cnt_inc      = 1'b1;
                                end else begin
                                    letter_idx_d = letter_idx_q + 1'b1;
                                end
                            end else begin
                                sym_idx_d = sym_idx_q + 1'b1;
                            end
                        end else if ((sym_idx_q != '0) && (sym == first_sym)) begin
                            // The failing symbol may itself start the current letter again.
                            sym_idx_d = SIW'(1);
                        end else begin
                            sym_idx_d = '0;
                        end
                    end
                end
                StDone: begin
                    if (CONTINUOUS != 0) begin
                        state_d      = StHunt;
                        letter_det_d = '0;
                    end else begin
                        state_d = StHold;
                    end
                    letter_idx_d = '0;
                    sym_idx_d    = '0;
                end
                StHold: ;
                default: begin
                    state_d      = StHunt;
                    letter_idx_d = '0;
                    sym_idx_d    = '0;
                    letter_det_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StHunt;
            letter_idx_q <= '0;
            sym_idx_q    <= '0;
            letter_det_q <= '0;
            pattern_q    <= RST_PATTERN;
        end else begin
            state_q      <= state_d;
            letter_idx_q <= letter_idx_d;
            sym_idx_q    <= sym_idx_d;
            letter_det_q <= letter_det_d;
            pattern_q    <= pattern_d;
        end
    end

    sat_counter #(
        .COUNT_W(COUNT_W)
    ) u_sat_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (cnt_inc),
        .clr  (cnt_clr),
        .count(match_count)
    );

    assign letter_detected = letter_det_q;
    assign seq_done        = (state_q == StDone);

endmodule

// File: tb/tb_pattern_detector_seq.sv
// Bench for pattern_detector_seq: three instances (default, hold mode, 2-bit counter)
// share one stimulus stream and are compared against a flat-position reference model.
module tb_pattern_detector_seq;

    localparam int SPL   = 2;
    localparam int TOTAL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sym = '0;
    logic       sym_valid = 1'b0;
    logic       clear = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = '0;

    logic [1:0] ld_c, ld_h, ld_s;
    logic       done_c, done_h, done_s;
    logic [7:0] cnt_c, cnt_h;
    logic [1:0] cnt_s;

    int checks = 0;
    int errors = 0;

    // Model: pos = symbols matched so far (0..TOTAL); st 0=hunt, 1=done, 2=hold.
    int         pos [3];
    int         st  [3];
    int         cnt [3];
    int         cmax[3] = '{255, 255, 3};
    int         cont[3] = '{1, 0, 1};
    logic [7:0] mpat = 8'b00_11_10_11;

    always #5 clk = ~clk;

    pattern_detector_seq u_cont (
        .clk(clk), .rst(rst), .sym(sym), .sym_valid(sym_valid), .clear(clear),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .letter_detected(ld_c), .seq_done(done_c), .match_count(cnt_c)
    );

    pattern_detector_seq #(.CONTINUOUS(0)) u_hold (
        .clk(clk), .rst(rst), .sym(sym), .sym_valid(sym_valid), .clear(clear),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .letter_detected(ld_h), .seq_done(done_h), .match_count(cnt_h)
    );

    pattern_detector_seq #(.COUNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .sym(sym), .sym_valid(sym_valid), .clear(clear),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .letter_detected(ld_s), .seq_done(done_s), .match_count(cnt_s)
    );

    function automatic int pat_sym(input logic [7:0] p, input int k);
        logic [7:0] t;
        t = p >> (2 * k);
        return int'(t[1:0]);
    endfunction

    task automatic check(input string tag, input int inst, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s inst%0d got %0d expected %0d", tag, inst, got, exp);
        end
    endtask

    task automatic check_all();
        int eld [3];
        int edn [3];
        for (int i = 0; i < 3; i++) begin
            eld[i] = (1 << (pos[i] / SPL)) - 1;
            edn[i] = (st[i] == 1) ? 1 : 0;
        end
        check("letter_detected", 0, int'(ld_c), eld[0]);
        check("seq_done", 0, int'(done_c), edn[0]);
        check("match_count", 0, int'(cnt_c), cnt[0]);
        check("letter_detected", 1, int'(ld_h), eld[1]);
        check("seq_done", 1, int'(done_h), edn[1]);
        check("match_count", 1, int'(cnt_h), cnt[1]);
        check("letter_detected", 2, int'(ld_s), eld[2]);
        check("seq_done", 2, int'(done_s), edn[2]);
        check("match_count", 2, int'(cnt_s), cnt[2]);
    endtask

    task automatic step(input logic r, input logic c, input logic l, input logic v,
                        input logic [1:0] s, input logic [7:0] p);
        int off;
        rst = r; clear = c; cfg_load = l; sym_valid = v; sym = s; cfg_pattern = p;
        for (int i = 0; i < 3; i++) begin
            if (r || c) begin
                pos[i] = 0; st[i] = 0;
                cnt[i] = 0;
            end else if (l) begin
                pos[i] = 0; st[i] = 0;
            end else if (st[i] == 1) begin
                if (cont[i] != 0) begin
                    st[i] = 0; pos[i] = 0;
                end else begin
                    st[i] = 2;
                end
            end else if (st[i] == 0 && v) begin
                if (int'(s) == pat_sym(mpat, pos[i])) begin
                    pos[i]++;
                    if (pos[i] == TOTAL) begin
                        st[i] = 1;
                        if (cnt[i] < cmax[i]) cnt[i]++;
                    end
                end else begin
                    off = pos[i] % SPL;
                    if (off != 0 && int'(s) == pat_sym(mpat, pos[i] - off)) pos[i] = pos[i] - off + 1;
                    else pos[i] = pos[i] - off;
                end
            end
        end
        if (r) mpat = 8'b00_11_10_11;
        else if (!c && l) mpat = p;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic feed(input logic [1:0] s);
        step(1'b0, 1'b0, 1'b0, 1'b1, s, 8'h00);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'($urandom), 8'h00);
    endtask

    task automatic do_clear();
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
    endtask

    task automatic full_seq();
        feed(2'b11); feed(2'b10); feed(2'b11); feed(2'b00);
    endtask

    initial begin
        logic [1:0] rs;
        logic [7:0] rp;
        int         r;

        // Reset
        step(1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
        check("reset_ld", 0, int'(ld_c), 0);

        // Basic detection with leading noise
        feed(2'b00); feed(2'b11); feed(2'b10);
        check("first_letter", 0, int'(ld_c), 1);
        feed(2'b11); feed(2'b00);
        check("both_letters", 0, int'(ld_c), 3);
        check("done_pulse", 0, int'(done_c), 1);
        check("count_one", 0, int'(cnt_c), 1);
        idle();
        check("restart_clears", 0, int'(ld_c), 0);
        check("done_one_cycle", 0, int'(done_c), 0);
        idle();

        // Retry rule and mismatch keeping earlier letters
        do_clear();
        feed(2'b11); feed(2'b11); feed(2'b10);
        check("retry_letter0", 0, int'(ld_c), 1);
        feed(2'b11); feed(2'b01); feed(2'b00);
        check("mismatch_keeps", 0, int'(ld_c), 1);
        check("no_done", 0, int'(done_c), 0);

        // Stalls between symbols
        do_clear();
        for (int k = 0; k < TOTAL; k++) begin
            for (int j = 0; j < 3; j++) idle();
            feed(2'(pat_sym(mpat, k)));
        end
        check("stall_done", 0, int'(done_c), 1);
        idle();

        // Hold mode: second sequence is ignored
        do_clear();
        full_seq();
        idle();
        full_seq();
        check("hold_ld", 1, int'(ld_h), 3);
        check("hold_done_low", 1, int'(done_h), 0);
        check("hold_count", 1, int'(cnt_h), 1);
        do_clear();
        check("hold_clear", 1, int'(ld_h), 0);

        // Saturation with a 2-bit counter
        do_clear();
        for (int n = 1; n <= 5; n++) begin
            full_seq();
            check("sat_count", 2, int'(cnt_s), (n > 3) ? 3 : n);
            idle();
        end

        // cfg_load discards the coincident symbol, then the new pattern matches
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 8'b10_10_01_01);
        check("load_discard", 0, int'(ld_c), 0);
        feed(2'b01); feed(2'b01); feed(2'b10); feed(2'b10);
        check("load_done", 0, int'(done_c), 1);
        idle();
        feed(2'b01);
        step(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 8'h00);
        check("rst_mid_ld", 0, int'(ld_c), 0);
        check("rst_mid_cnt", 0, int'(cnt_c), 0);
        full_seq();
        check("rst_pattern_back", 0, int'(done_c), 1);

        // Randomised traffic biased toward the expected symbol
        for (int n = 0; n < 800; n++) begin
            r  = int'($urandom_range(0, 99));
            rs = 2'($urandom);
            if ($urandom_range(0, 99) < 60 && st[0] == 0) rs = 2'(pat_sym(mpat, pos[0]));
            rp = ($urandom_range(0, 1) == 1) ? 8'(8'($urandom)) : 8'b10_10_01_01;
            if (r < 1) step(1'b1, 1'b0, 1'b0, 1'($urandom), rs, 8'h00);
            else if (r < 3) step(1'b0, 1'b1, 1'($urandom), 1'($urandom), rs, rp);
            else if (r < 5) step(1'b0, 1'b0, 1'b1, 1'($urandom), rs, rp);
            else step(1'b0, 1'b0, 1'b0, ($urandom_range(0, 3) != 0), rs, 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
